// File: rtl/branch_hazard_ctrl_if.sv
// Signal bundle between the ID-stage pipeline context and the branch hazard controller.
// The pipeline side drives the master modport; the controller uses the slave modport.
interface branch_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hold;
    logic             id_branch;
    logic             id_fast_jump;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             mem_reg_write;
    logic [4:0]       mem_rd;
    logic             bdc_pc_write;
    logic             forwarding_rs1;
    logic             forwarding_rs2;
    logic             stall_if_id;
    logic             bubble_ex;
    logic             pc_write;
    logic             flush_if_id;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output hold, id_branch, id_fast_jump, id_rs1, id_rs2,
               ex_reg_write, ex_mem_read, ex_rd, mem_reg_write, mem_rd, bdc_pc_write,
        input  forwarding_rs1, forwarding_rs2, stall_if_id, bubble_ex,
               pc_write, flush_if_id, stall_count, taken_count
    );

    modport slave (
        input  hold, id_branch, id_fast_jump, id_rs1, id_rs2,
               ex_reg_write, ex_mem_read, ex_rd, mem_reg_write, mem_rd, bdc_pc_write,
        output forwarding_rs1, forwarding_rs2, stall_if_id, bubble_ex,
               pc_write, flush_if_id, stall_count, taken_count
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Branch-operand hazard controller: EX forwarding select, load/MEM stalls,
// redirect gating with IF/ID flush, and saturating stall/taken counters.
module branch_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    branch_hazard_ctrl_if.slave bus
);
    typedef enum logic { RUN, STALL } state_e;

    state_e           state_q;
    logic [1:0]       cnt_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic [1:0][4:0]  rs;
    logic [1:0]       ex_m, mem_m, ex_fwd;
    logic [1:0]       need;
    logic             stall, redirect;

    assign rs[0] = bus.id_rs1;
    assign rs[1] = bus.id_rs2;

    // JAL reads no register operand, so only conditional branches can match.
    for (genvar n = 0; n < 2; n++) begin : g_match
        assign ex_m[n]  = bus.id_branch && bus.ex_reg_write  && (bus.ex_rd  == rs[n]) && (rs[n] != 5'd0);
        assign mem_m[n] = bus.id_branch && bus.mem_reg_write && (bus.mem_rd == rs[n]) && (rs[n] != 5'd0);
    end

    // EX match shadows MEM match; a load in EX is only readable at WB (2 cycles).
    always_comb begin
        need   = 2'd0;
        ex_fwd = 2'b00;
        for (int n = 0; n < 2; n++) begin
            if (ex_m[n]) begin
                if (bus.ex_mem_read) need = 2'd2;
                else                 ex_fwd[n] = 1'b1;
            end else if (mem_m[n] && need == 2'd0) begin
                need = 2'd1;
            end
        end
    end

    assign stall    = (state_q == RUN && need != 2'd0) || (state_q == STALL);
    assign redirect = bus.bdc_pc_write && (bus.id_branch || bus.id_fast_jump) && !stall && !bus.hold;

    assign stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign taken_cnt_d = (&taken_cnt_q) ? taken_cnt_q : taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= 2'd0;
            stall_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else if (!bus.hold) begin
            case (state_q)
                RUN: begin
                    if (need == 2'd2) begin
                        state_q <= STALL;
                        cnt_q   <= 2'd1;
                    end
                end
                STALL: begin
                    if (cnt_q == 2'd1) begin
                        state_q <= RUN;
                        cnt_q   <= 2'd0;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: state_q <= RUN;
            endcase
            if (stall)    stall_cnt_q <= stall_cnt_d;
            if (redirect) taken_cnt_q <= taken_cnt_d;
        end
    end

    // Everything is masked while reset is asserted.
    assign bus.forwarding_rs1 = !rst && !bus.hold && !stall && ex_fwd[0];
    assign bus.forwarding_rs2 = !rst && !bus.hold && !stall && ex_fwd[1];
    assign bus.stall_if_id    = !rst && (stall || bus.hold);
    assign bus.bubble_ex      = !rst && stall && !bus.hold;
    assign bus.pc_write       = !rst && redirect;
    assign bus.flush_if_id    = !rst && redirect;
    assign bus.stall_count    = rst ? '0 : stall_cnt_q;
    assign bus.taken_count    = rst ? '0 : taken_cnt_q;
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: a stall-budget model checked every cycle,
// plus literal expectations; a CNT_W=2 copy exercises counter saturation.
module tb_branch_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic hold, br, jal, exwe, exld, memwe, bdc;
    logic [4:0] rs1, rs2, exrd, memrd;

    int n_tot = 0;
    int n_pass = 0;

    branch_hazard_ctrl_if #(.CNT_W(16)) ifa ();
    branch_hazard_ctrl_if #(.CNT_W(2))  ifb ();

    assign ifa.hold = hold;  assign ifa.id_branch = br;  assign ifa.id_fast_jump = jal;
    assign ifa.id_rs1 = rs1; assign ifa.id_rs2 = rs2;    assign ifa.ex_reg_write = exwe;
    assign ifa.ex_mem_read = exld; assign ifa.ex_rd = exrd; assign ifa.mem_reg_write = memwe;
    assign ifa.mem_rd = memrd; assign ifa.bdc_pc_write = bdc;
    assign ifb.hold = hold;  assign ifb.id_branch = br;  assign ifb.id_fast_jump = jal;
    assign ifb.id_rs1 = rs1; assign ifb.id_rs2 = rs2;    assign ifb.ex_reg_write = exwe;
    assign ifb.ex_mem_read = exld; assign ifb.ex_rd = exrd; assign ifb.mem_reg_write = memwe;
    assign ifb.mem_rd = memrd; assign ifb.bdc_pc_write = bdc;

    branch_hazard_ctrl #(.CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    branch_hazard_ctrl #(.CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: m_rem = stall cycles still owed from an earlier hazard; counts are unsaturated.
    int m_rem = 0;
    int m_sn = 0;
    int m_tn = 0;
    int need1, need2, need;
    logic e_stall, e_fwd1, e_fwd2, e_pcw;

    always_comb begin
        need1 = 0; need2 = 0;
        if (br && rs1 != 0) begin
            if (exwe && exrd == rs1)        need1 = exld ? 2 : 0;
            else if (memwe && memrd == rs1) need1 = 1;
        end
        if (br && rs2 != 0) begin
            if (exwe && exrd == rs2)        need2 = exld ? 2 : 0;
            else if (memwe && memrd == rs2) need2 = 1;
        end
        need    = (need1 > need2) ? need1 : need2;
        e_stall = (m_rem > 0) || (need > 0);
        e_fwd1  = !rst && !hold && !e_stall && br && rs1 != 0 && exwe && !exld && exrd == rs1;
        e_fwd2  = !rst && !hold && !e_stall && br && rs2 != 0 && exwe && !exld && exrd == rs2;
        e_pcw   = !rst && bdc && (br || jal) && !e_stall && !hold;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_rem = 0; m_sn = 0; m_tn = 0;
        end else if (!hold) begin
            if (e_stall) m_sn++;
            if (e_pcw)   m_tn++;
            if (m_rem > 0)     m_rem--;
            else if (need > 0) m_rem = need - 1;
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        chk("forwarding_rs1", ifa.forwarding_rs1, e_fwd1);
        chk("forwarding_rs2", ifa.forwarding_rs2, e_fwd2);
        chk("stall_if_id", ifa.stall_if_id, !rst && (e_stall || hold));
        chk("bubble_ex", ifa.bubble_ex, !rst && e_stall && !hold);
        chk("pc_write", ifa.pc_write, e_pcw);
        chk("flush_if_id", ifa.flush_if_id, e_pcw);
        chk("stall_count", ifa.stall_count, rst ? 0 : sat(m_sn, 65535));
        chk("taken_count", ifa.taken_count, rst ? 0 : sat(m_tn, 65535));
        chk("stall_count_w2", ifb.stall_count, rst ? 0 : sat(m_sn, 3));
        chk("taken_count_w2", ifb.taken_count, rst ? 0 : sat(m_tn, 3));
    end

    task automatic set_in(input logic b, input logic j, input logic [4:0] r1, input logic [4:0] r2,
                          input logic ew, input logic el, input logic [4:0] erd,
                          input logic mw, input logic [4:0] mrd, input logic pcw, input logic h);
        br = b; jal = j; rs1 = r1; rs2 = r2; exwe = ew; exld = el; exrd = erd;
        memwe = mw; memrd = mrd; bdc = pcw; hold = h;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int base;

    initial begin
        rst = 1'b1;
        idle();
        #1 chk("reset_stall_if_id", ifa.stall_if_id, 0);
        tick(); tick();
        rst = 1'b0;
        chk("reset_stall_count", ifa.stall_count, 0);

        // 1. ALU forward, also masked by hold
        set_in(1, 0, 5, 0, 1, 0, 5, 0, 0, 1, 1); #1;
        chk("t1_hold_fwd", ifa.forwarding_rs1, 0);
        chk("t1_hold_pcw", ifa.pc_write, 0);
        tick();
        set_in(1, 0, 5, 0, 1, 0, 5, 0, 0, 1, 0); #1;
        chk("t1_fwd", ifa.forwarding_rs1, 1);
        chk("t1_flush", ifa.flush_if_id, 1);
        tick();
        chk("t1_taken", ifa.taken_count, 1);
        idle(); tick();

        // 2. Load-use: two stall cycles as the load walks EX -> MEM -> WB
        set_in(1, 0, 0, 7, 1, 1, 7, 0, 0, 1, 0); #1;
        chk("t2_stall1", ifa.bubble_ex, 1);
        tick();
        set_in(1, 0, 0, 7, 0, 0, 0, 1, 7, 1, 0); #1;
        chk("t2_stall2", ifa.stall_if_id, 1);
        tick();
        set_in(1, 0, 0, 7, 0, 0, 0, 0, 0, 1, 0); #1;
        chk("t2_clear", ifa.stall_if_id, 0);
        chk("t2_pcw", ifa.pc_write, 1);
        tick();
        chk("t2_stall_count", ifa.stall_count, 2);
        idle(); tick();

        // 3. MEM dependency: single stall, no forwarding
        set_in(1, 0, 3, 0, 1, 0, 4, 1, 3, 0, 0); #1;
        chk("t3_stall", ifa.stall_if_id, 1);
        chk("t3_fwd", ifa.forwarding_rs1, 0);
        tick();
        set_in(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("t3_clear", ifa.stall_if_id, 0);
        tick();
        chk("t3_stall_count", ifa.stall_count, 3);

        // 4. x0 never matches; JAL never stalls
        set_in(1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0); #1;
        chk("t4_x0", ifa.stall_if_id, 0);
        tick();
        set_in(0, 1, 5, 5, 1, 1, 5, 1, 5, 1, 0); #1;
        chk("t4_jal_stall", ifa.stall_if_id, 0);
        chk("t4_jal_pcw", ifa.pc_write, 1);
        tick();
        idle(); tick();

        // 5. Hold in the middle of a load-use stall
        base = ifa.stall_count;
        set_in(1, 0, 0, 7, 1, 1, 7, 0, 0, 1, 0); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 7, 0, 0, 0, 1, 7, 1, 1); #1;
            chk("t5_hold_stall", ifa.stall_if_id, 1);
            chk("t5_hold_bubble", ifa.bubble_ex, 0);
            chk("t5_hold_frozen", ifa.stall_count, base + 1);
            tick();
        end
        set_in(1, 0, 0, 7, 0, 0, 0, 1, 7, 1, 0); #1;
        chk("t5_last_stall", ifa.bubble_ex, 1);
        tick();
        chk("t5_stall_count", ifa.stall_count, base + 2);
        set_in(1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("t5_clear", ifa.stall_if_id, 0);
        tick();

        // 6. Reset while in STALL, then saturation of the narrow counter
        set_in(1, 0, 0, 7, 1, 1, 7, 0, 0, 0, 0); tick();
        set_in(1, 0, 0, 7, 0, 0, 0, 1, 7, 0, 0);
        rst = 1'b1; #1;
        chk("t6_rst_mask", ifa.stall_if_id, 0);
        tick();
        rst = 1'b0;
        idle(); #1;
        chk("t6_no_residual", ifa.stall_if_id, 0);
        chk("t6_cnt_clear", ifa.stall_count, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        end
        chk("t6_sat_w2", ifb.taken_count, 3);
        chk("t6_taken_w16", ifa.taken_count, 5);
        idle(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
